// File: rtl/fetch_stage_pkg.sv
// Shared constants for the MIPS fetch slice.
//  WORD_W     : architectural word width
//  RESET_PC   : default PCF after reset
//  NOP_INSTR  : bubble encoding (sll $0,$0,0) placed in InstrD on flush/wait
//  pc_plus4() : sequential-PC helper, wraps modulo 2^32
package fetch_stage_pkg;
  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [WORD_W-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  typedef logic [WORD_W-1:0] word_t;

  function automatic word_t pc_plus4(input word_t pc);
    return pc + 32'd4;
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its neighbours (hazard unit,
// decode, instruction memory).
//  slave  : the fetch stage itself
//  master : everything around it (hazard unit, decode, imem, or a bench)
// Handshake: imem_addr is presented combinationally from pc_f every cycle;
// imem_ready=1 means imem_rdata is the word for imem_addr this cycle and it
// is consumed at the next rising edge. imem_rdata is don't-care otherwise.
// There is no backpressure toward memory: a fetch abandoned by a redirect is
// simply never consumed.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic  stall_f;
  logic  stall_d;
  logic  pc_src_d;
  logic  jump_d;
  word_t pc_branch_d;
  word_t pc_jump_d;
  word_t imem_addr;
  word_t imem_rdata;
  logic  imem_ready;
  word_t pc_f;
  word_t instr_d;
  word_t pc_plus4_d;
  logic  valid_d;

  modport slave (
    input  stall_f, stall_d, pc_src_d, jump_d, pc_branch_d, pc_jump_d,
    input  imem_rdata, imem_ready,
    output imem_addr, pc_f, instr_d, pc_plus4_d, valid_d
  );

  modport master (
    output stall_f, stall_d, pc_src_d, jump_d, pc_branch_d, pc_jump_d,
    output imem_rdata, imem_ready,
    input  imem_addr, pc_f, instr_d, pc_plus4_d, valid_d
  );
endinterface

// File: rtl/fetch_stage_if_id.sv
// IF/ID pipeline register with enable and synchronous clear.
//  clk, rst_n : clock, async active-low reset
//  en         : capture this edge (0 = hold, wins over clr)
//  clr        : when enabled, load a bubble instead of the inputs
//  instr_in, pc_plus4_in : fetched word and its PC+4
//  instr_d, pc_plus4_d, valid_d : registered outputs to decode
module if_id_register
  import fetch_stage_pkg::*;
#(
  parameter word_t NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  logic  clr,
  input  word_t instr_in,
  input  word_t pc_plus4_in,
  output word_t instr_d,
  output word_t pc_plus4_d,
  output logic  valid_d
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d    <= NOP_INSTR;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (en) begin
      if (clr) begin
        instr_d    <= NOP_INSTR;
        pc_plus4_d <= '0;
        valid_d    <= 1'b0;
      end else begin
        instr_d    <= instr_in;
        pc_plus4_d <= pc_plus4_in;
        valid_d    <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select, +4 adder and the
// IF/ID register feeding decode.
//  clk   : rising-edge clock
//  rst_n : asynchronous active-low reset
//  bus   : fetch_stage_if.slave (hazard stalls, decode redirects, imem
//          address/data/ready, PCF and IF/ID outputs)
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC  = DEFAULT_RESET_PC,
  parameter word_t NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.slave  bus
);
  word_t pc_q;
  word_t pc_next;
  word_t pc_plus4_f;
  logic  redirect;

  assign pc_plus4_f    = pc_plus4(pc_q);
  assign redirect      = bus.jump_d | bus.pc_src_d;
  assign bus.imem_addr = pc_q;
  assign bus.pc_f      = pc_q;

  // A stall suppresses redirects entirely (the hazard unit re-presents
  // them); otherwise a redirect is taken even during a memory wait, which
  // abandons the in-flight fetch.
  always_comb begin
    pc_next = pc_q;
    if (bus.stall_f)         pc_next = pc_q;
    else if (bus.jump_d)     pc_next = bus.pc_jump_d;
    else if (bus.pc_src_d)   pc_next = bus.pc_branch_d;
    else if (!bus.imem_ready) pc_next = pc_q;
    else                     pc_next = pc_plus4_f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_next;
  end

  // Wrong-path slot and memory waits both turn into a bubble in decode.
  if_id_register #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (!bus.stall_d),
    .clr         (redirect | !bus.imem_ready),
    .instr_in    (bus.imem_rdata),
    .pc_plus4_in (pc_plus4_f),
    .instr_d     (bus.instr_d),
    .pc_plus4_d  (bus.pc_plus4_d),
    .valid_d     (bus.valid_d)
  );

  // Holding decode while fetch advances would drop an instruction.
  a_no_stall_d_without_f: assert property (
    @(posedge clk) disable iff (!rst_n) !(bus.stall_d && !bus.stall_f)
  );
endmodule
